// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: the side-result entry
// carried through the FIFO and onto the register-file write port.
package wb_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        fp;
    } wb_entry_t;

    localparam int        WB_FIFO_DEPTH_DEFAULT = 4;
    localparam logic [4:0] REG_X0               = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries. The head is presented combinationally;
// the pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == COUNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; the count alone decides which entries are live,
    // so stale data in an empty slot is never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back stage: merges pipeline, FPU and load results onto the shared register
// write port and tracks outstanding long-latency destinations for decode.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_result,
    input  logic        pipe_fp,
    input  logic        fpu_valid,
    input  logic [4:0]  fpu_rd,
    input  logic [31:0] fpu_result,
    input  logic        fpu_fp,
    output logic        fpu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_result,
    input  logic        ld_fp,
    output logic        ld_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_fp,
    output logic [4:0]  rd_w,
    output logic [31:0] result_w,
    output logic        reg_write_w,
    output logic        fpu_reg_write_w,
    output logic [31:0] busy_int,
    output logic [31:0] busy_fp
);

    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [COUNT_W-1:0] fifo_count;
    wb_entry_t          push_entry;
    wb_entry_t          head_entry;
    wb_entry_t          sel_entry;
    logic               sel_valid;
    logic [31:0]        busy_int_next;
    logic [31:0]        busy_fp_next;

    // FPU has fixed priority over the load unit for the single enqueue slot.
    assign fpu_ready = !fifo_full && !rst;
    assign ld_ready  = !fifo_full && !fpu_valid && !rst;
    assign fifo_push = (fpu_valid && fpu_ready) || (ld_valid && ld_ready);

    assign fifo_pop  = !pipe_valid && !fifo_empty;
    assign sel_valid = pipe_valid || fifo_pop;

    // NOTE: every variable assigned in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        push_entry = '{rd: ld_rd, result: ld_result, fp: ld_fp};
        if (fpu_valid) begin
            push_entry = '{rd: fpu_rd, result: fpu_result, fp: fpu_fp};
        end

        sel_entry = head_entry;
        if (pipe_valid) begin
            sel_entry = '{rd: pipe_rd, result: pipe_result, fp: pipe_fp};
        end
    end

    // Clear for the dequeued destination first, then set for a new issue, so a
    // newer op claiming the same register keeps it busy.
    always_comb begin
        busy_int_next = busy_int;
        busy_fp_next  = busy_fp;
        if (fifo_pop) begin
            if (head_entry.fp) begin
                busy_fp_next[head_entry.rd] = 1'b0;
            end else begin
                busy_int_next[head_entry.rd] = 1'b0;
            end
        end
        if (issue_valid) begin
            if (issue_fp) begin
                busy_fp_next[issue_rd] = 1'b1;
            end else if (issue_rd != REG_X0) begin
                busy_int_next[issue_rd] = 1'b1;
            end
        end
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_w            <= REG_X0;
            result_w        <= '0;
            reg_write_w     <= 1'b0;
            fpu_reg_write_w <= 1'b0;
            busy_int        <= '0;
            busy_fp         <= '0;
        end else begin
            if (sel_valid) begin
                rd_w     <= sel_entry.rd;
                result_w <= sel_entry.result;
            end
            reg_write_w     <= sel_valid && !sel_entry.fp && (sel_entry.rd != REG_X0);
            fpu_reg_write_w <= sel_valid && sel_entry.fp;
            busy_int        <= busy_int_next;
            busy_fp         <= busy_fp_next;
        end
    end

    count_in_range: assert property (@(posedge clk) fifo_count <= COUNT_W'(FIFO_DEPTH));

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-back stage of the pipelined core: the single writer of the integer register file and the FPU register file, which the decode stage reads. It merges three result sources onto the one shared write port (`rd_w` / `result_w` / `reg_write_w` / `fpu_reg_write_w`):
- the in-order pipeline result from the memory stage;
- the multi-cycle FPU;
- the load unit.

It also keeps a destination scoreboard so decode can stall on registers with outstanding long-latency writes.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4. Entries in the side-result FIFO. Power of two, at least 2.

Ports:
- `clk`  in  1  Core clock.
- `rst`  in  1  Synchronous, active-high reset.
- `pipe_valid`  in  1  In-order pipeline result wants to write this cycle. Always accepted.
- `pipe_rd`  in  5  Pipeline destination register.
- `pipe_result`  in  32  Pipeline write data.
- `pipe_fp`  in  1  1 = destination is in the FPU register file.
- `fpu_valid`, `fpu_rd`[5], `fpu_result`[32], `fpu_fp`  in  FPU result offer.
- `fpu_ready`  out  1  FPU result accepted when `fpu_valid && fpu_ready`.
- `ld_valid`, `ld_rd`[5], `ld_result`[32], `ld_fp`  in  Load-unit result offer.
- `ld_ready`  out  1  Load result accepted when `ld_valid && ld_ready`.
- `issue_valid`  in  1  Decode is issuing a long-latency op (FPU or load) with a pending destination.
- `issue_rd`  in  5  Destination register of that op.
- `issue_fp`  in  1  1 = that destination is in the FPU register file.
- `rd_w`  out  5  Write address, shared by both register files.
- `result_w`  out  32  Write data.
- `reg_write_w`  out  1  Integer register-file write enable.
- `fpu_reg_write_w`  out  1  FPU register-file write enable.
- `busy_int`  out  32  Scoreboard for integer registers; bit *n* = pending side write to x*n*.
- `busy_fp`  out  32  Scoreboard for FPU registers; bit *n* = pending side write to f*n*.

## Operation
Side-result FIFO:
- Holds {rd, result, fp}. At most one enqueue per cycle.
- Fixed priority, FPU over load:
  - `fpu_ready = !full && !rst`
  - `ld_ready = !full && !fpu_valid && !rst`
- Both ready signals are combinational from the registered FIFO count and the inputs.

Write-port arbitration (evaluated each cycle):
- If `pipe_valid`: select the pipe result.
- Else if the FIFO is non-empty: dequeue the head and select it.
- Else: no write.
- A pipe result always wins. The FIFO drains only in cycles with no pipe write.
- Enqueue and dequeue in the same cycle are legal, including when the FIFO is full: when full, `ready` is low, so there is no enqueue that cycle, and the dequeue frees a slot for the next cycle.

Output register:
- The selected entry is registered into `rd_w` / `result_w`.
- `reg_write_w = sel && !fp && rd != 0`. Integer writes to x0 are suppressed, but `rd_w` still updates.
- `fpu_reg_write_w = sel && fp`. f0 is writable.
- When nothing is selected, both enables go to 0 and `rd_w` / `result_w` hold their previous value.

Scoreboard:
- `issue_valid` sets `busy[issue_fp][issue_rd]` at the clock edge. Issues to integer x0 are ignored, so `busy_int[0]` is always 0.
- A FIFO dequeue clears the busy bit of its destination at the same edge as the output register loads.
- If the same bit is set and cleared in the same cycle, set wins (a newer op owns the register).
- Pipe writes never touch the scoreboard.
- Decode must stall any read of a busy register. Ordering between pipe and side writes to the same register is decode's responsibility.

Reset:
- FIFO emptied; any entries in flight are discarded.
- `busy_*` cleared.
- `rd_w = 0`, `result_w = 0`, `reg_write_w = 0`, `fpu_reg_write_w = 0`.
- `fpu_ready` and `ld_ready` are 0 in every cycle `rst` is high. An offer made during reset is not taken.

## Timing
- Pipe result: presented in cycle N, visible on the write port in N+1. The register file writes on the falling edge, so decode in N+1 reads the new value.
- Side result: accepted in cycle N, written at the earliest in N+2 (no fall-through). Busy clears at the N+2 edge.
- Back-pressure: side latency grows by one cycle per consecutive `pipe_valid` cycle. A FIFO entry can starve while `pipe_valid` is held high; this is acceptable.
- Full FIFO: `fpu_ready = ld_ready = 0` in the same cycle the count reaches `FIFO_DEPTH`. Ready rises again in the cycle after the first dequeue.
- All outputs except `fpu_ready` and `ld_ready` are registered.

## Structure
- Package `wb_pkg`:
  - `wb_entry_t` struct {`logic [4:0] rd`; `logic [31:0] result`; `logic fp`}.
  - Constants `WB_FIFO_DEPTH_DEFAULT = 4` and `REG_X0 = 5'd0`.
- Sub-module `wb_fifo`: synchronous FIFO of `wb_entry_t` with push/pop, full/empty, a `$clog2(FIFO_DEPTH)+1`-bit count, and wrapping read/write pointers.
- The top-level module holds the arbitration logic, the output register and the two 32-bit scoreboard vectors.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `fpu_valid = 1`. Expect both readys at 0, every output at 0, and no write afterwards.
- **Pipe-only:** `pipe_valid`, `rd = 5`, `result = 0xDEADBEEF`, `fp = 0` at cycle N. Expect `reg_write_w = 1`, `rd_w = 5`, `result_w = 0xDEADBEEF` at N+1. Repeat with `rd = 0`: `reg_write_w = 0`.
- **FPU path:** issue f3, then FPU result `0x3F800000` to f3. Expect `busy_fp[3] = 1` until write-back; `fpu_reg_write_w = 1` two cycles after acceptance; `busy_fp[3] = 0` the same edge.
- **Starvation and fill:** hold `pipe_valid` for 6 cycles while alternating FPU and load offers. Expect the FIFO to fill after 4 accepts and both readys to drop. After `pipe_valid` falls, entries drain in acceptance order, one per cycle.
- **Simultaneous offers:** FPU and load valid in the same cycle with the FIFO empty. Expect `ld_ready = 0`, FPU enqueued first, load accepted the next cycle.
- **Set/clear collision:** dequeue to x7 in the same cycle as a new `issue_rd = 7`. Expect `busy_int[7]` to stay 1.
